// File: rtl/board_reader.sv
// board_reader: snapshots the packed tic-tac-toe board on start, streams the
// nine cells (address + natural-order state) over valid/ready, and publishes a
// registered winner code when the last cell is accepted.
//
// Ports:
//   ph1      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   scan request, sampled only while idle
//   gBoard   in   [17:0] packed board, each cell stored bit-flipped
//   rdReady  in   consumer accepts current cell
//   rdValid  out  current cell valid
//   rdAddr   out  [3:0] cell index 0..8, 4'hF when not scanning
//   rdState  out  [1:0] cell state (00 empty, 11 player1, 10 player2)
//   busy     out  high while scanning or finishing
//   done     out  one-cycle pulse when the scan completes
//   winner   out  [1:0] 11 player1, 10 player2, 01 tie, 00 no result
module board_reader (
  input  logic        ph1,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] gBoard,
  input  logic        rdReady,
  output logic        rdValid,
  output logic [3:0]  rdAddr,
  output logic [1:0]  rdState,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner
);

  localparam int unsigned NCELL     = 9;
  localparam int unsigned BOARD_W   = 2 * NCELL;
  localparam logic [3:0]  LAST_CELL = 4'd8;
  localparam logic [3:0]  NO_ADDR   = 4'hF;

  localparam logic [1:0] WIN_P1  = 2'b11;
  localparam logic [1:0] WIN_P2  = 2'b10;
  localparam logic [1:0] WIN_TIE = 2'b01;
  localparam logic [1:0] WIN_NONE = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           idx;
  logic [BOARD_W-1:0]   shadow;

  // Natural-order state of cell i: the packed board stores each pair flipped.
  function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b,
                                         input logic [3:0]         i);
    logic [1:0] c;
    c = 2'b00;
    for (int k = 0; k < int'(NCELL); k++) begin
      if (i == 4'(k)) c = {b[2*k], b[2*k+1]};
    end
    return c;
  endfunction

  // True when any row, column or diagonal of the mask is fully set.
  function automatic logic has_line(input logic [8:0] m);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  // Result of the snapshot; invalid code 01 counts as empty everywhere.
  logic [8:0] p1_mask;
  logic [8:0] p2_mask;
  logic [1:0] win_c;

  always_comb begin
    p1_mask = '0;
    p2_mask = '0;
    for (int k = 0; k < int'(NCELL); k++) begin
      p1_mask[k] = shadow[2*k] &  shadow[2*k+1];
      p2_mask[k] = shadow[2*k] & ~shadow[2*k+1];
    end
    win_c = WIN_NONE;
    if (has_line(p1_mask))          win_c = WIN_P1;
    else if (has_line(p2_mask))     win_c = WIN_P2;
    else if (&(p1_mask | p2_mask))  win_c = WIN_TIE;
  end

  // Scan controller; every output is a register updated alongside the state.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 4'd0;
      shadow  <= '0;
      rdValid <= 1'b0;
      rdAddr  <= NO_ADDR;
      rdState <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      winner  <= WIN_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shadow  <= gBoard;
            idx     <= 4'd0;
            state   <= SCAN;
            rdValid <= 1'b1;
            rdAddr  <= 4'd0;
            rdState <= cell_at(gBoard, 4'd0);
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          // rdValid is always high here, so rdReady alone marks a transfer.
          if (rdReady) begin
            if (idx == LAST_CELL) begin
              winner  <= win_c;
              state   <= DONE;
              rdValid <= 1'b0;
              rdAddr  <= NO_ADDR;
              rdState <= 2'b00;
              done    <= 1'b1;
            end else begin
              idx     <= idx + 4'd1;
              rdAddr  <= idx + 4'd1;
              rdState <= cell_at(shadow, idx + 4'd1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= 4'd0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          rdValid <= 1'b0;
          rdAddr  <= NO_ADDR;
          rdState <= 2'b00;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_reader.sv
// Directed bench for board_reader: scans fixed boards and compares every
// streamed cell, the done pulse timing and the winner against hand values.
module tb_board_reader;

  logic        ph1;
  logic        reset;
  logic        start;
  logic [17:0] gBoard;
  logic        rdReady;
  logic        rdValid;
  logic [3:0]  rdAddr;
  logic [1:0]  rdState;
  logic        busy;
  logic        done;
  logic [1:0]  winner;

  int checks   = 0;
  int failures = 0;

  logic [1:0] cells [9];
  logic [1:0] prev_win;

  board_reader dut (
    .ph1     (ph1),
    .reset   (reset),
    .start   (start),
    .gBoard  (gBoard),
    .rdReady (rdReady),
    .rdValid (rdValid),
    .rdAddr  (rdAddr),
    .rdState (rdState),
    .busy    (busy),
    .done    (done),
    .winner  (winner)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Encode natural cell codes into the flipped packed layout.
  function automatic logic [17:0] pack_board();
    logic [17:0] b;
    b = '0;
    for (int k = 0; k < 9; k++) begin
      b[2*k]   = cells[k][1];
      b[2*k+1] = cells[k][0];
    end
    return b;
  endfunction

  function automatic void set_cells(input logic [17:0] natural_cells);
    for (int k = 0; k < 9; k++) cells[k] = {natural_cells[2*k+1], natural_cells[2*k]};
  endfunction

  // One full scan in lock-step with the DUT; stall/snapshot options are per-call.
  task automatic run_scan(input logic [1:0] exp_win, input int stall_at,
                          input int stall_n, input bit snap);
    logic [17:0] b;
    b = pack_board();
    @(negedge ph1);
    gBoard  = b;
    rdReady = 1'b1;
    start   = 1'b1;
    @(negedge ph1);
    start = 1'b0;
    check("win_hold_c1", 32'(winner), 32'(prev_win));
    for (int i = 0; i < 9; i++) begin
      check("valid", 32'(rdValid), 32'd1);
      check("addr",  32'(rdAddr),  32'(i));
      check("state", 32'(rdState), 32'(cells[i]));
      check("busy",  32'(busy),    32'd1);
      if (snap && i == 2) gBoard = '1;
      if (snap && i == 3) start = 1'b1;
      if (snap && i == 4) start = 1'b0;
      if (i == stall_at) begin
        rdReady = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge ph1);
          check("stall_addr",  32'(rdAddr),  32'(i));
          check("stall_state", 32'(rdState), 32'(cells[i]));
          check("stall_valid", 32'(rdValid), 32'd1);
          check("stall_done",  32'(done),    32'd0);
        end
        rdReady = 1'b1;
      end
      @(negedge ph1);
    end
    check("done_pulse", 32'(done),    32'd1);
    check("winner",     32'(winner),  32'(exp_win));
    check("done_valid", 32'(rdValid), 32'd0);
    check("done_addr",  32'(rdAddr),  32'hF);
    check("done_busy",  32'(busy),    32'd1);
    @(negedge ph1);
    check("idle_done", 32'(done),   32'd0);
    check("idle_busy", 32'(busy),   32'd0);
    check("idle_addr", 32'(rdAddr), 32'hF);
    check("idle_win",  32'(winner), 32'(exp_win));
    if (snap) begin
      for (int s = 0; s < 3; s++) begin
        @(negedge ph1);
        check("snap_one_done", 32'(done), 32'd0);
        check("snap_no_rescan", 32'(busy), 32'd0);
      end
    end
    prev_win = exp_win;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    gBoard   = '0;
    rdReady  = 1'b1;
    prev_win = 2'b00;
    repeat (2) @(negedge ph1);
    check("rst_valid", 32'(rdValid), 32'd0);
    check("rst_addr",  32'(rdAddr),  32'hF);
    check("rst_state", 32'(rdState), 32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_win",   32'(winner),  32'd0);
    reset = 1'b0;
    @(negedge ph1);

    // Row win for player1: gBoard 18'h0003F.
    set_cells({2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11});
    check("row_pack", 32'(pack_board()), 32'h0003F);
    run_scan(2'b11, -1, 0, 1'b0);

    // Column win for player2 exercising the bit flip: gBoard 18'h01041.
    set_cells({2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10});
    check("col_pack", 32'(pack_board()), 32'h01041);
    run_scan(2'b10, -1, 0, 1'b0);

    // Full board with no line: tie.
    set_cells({2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11});
    run_scan(2'b01, -1, 0, 1'b0);

    // Same board with cell 8 empty: no result.
    cells[8] = 2'b00;
    run_scan(2'b00, -1, 0, 1'b0);

    // Invalid code 01 in cell 8 counts as empty but streams unchanged.
    cells[8] = 2'b01;
    run_scan(2'b00, -1, 0, 1'b0);

    // Backpressure: three stalled cycles at address 4, tie board.
    cells[8] = 2'b11;
    run_scan(2'b01, 4, 3, 1'b0);

    // Snapshot isolation: board rewritten and start pulsed mid-scan.
    set_cells({2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11});
    run_scan(2'b11, -1, 0, 1'b1);

    // Asynchronous reset while address 5 is on the bus.
    set_cells({2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10});
    @(negedge ph1);
    gBoard  = pack_board();
    rdReady = 1'b1;
    start   = 1'b1;
    @(negedge ph1);
    start = 1'b0;
    repeat (5) @(negedge ph1);
    check("pre_rst_addr", 32'(rdAddr), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(rdValid), 32'd0);
    check("arst_addr",  32'(rdAddr),  32'hF);
    check("arst_busy",  32'(busy),    32'd0);
    check("arst_win",   32'(winner),  32'd0);
    @(negedge ph1);
    reset = 1'b0;
    for (int s = 0; s < 12; s++) begin
      @(negedge ph1);
      check("arst_no_done", 32'(done), 32'd0);
    end
    prev_win = 2'b00;
    run_scan(2'b10, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
